// File: rtl/baccarat_pkg.sv
// Shared types and card rules for the baccarat controller.
// Ranks 1..13 encode A..K; 0 means an empty card slot.
package baccarat_pkg;

  localparam int RANK_W  = 4;
  localparam int SCORE_W = 4;

  localparam logic [SCORE_W-1:0] NAT_MIN    = 4'd8;
  localparam logic [SCORE_W-1:0] P_DRAW_MAX = 4'd5;

  typedef enum logic [3:0] {
    DEAL_P1,
    DEAL_D1,
    DEAL_P2,
    DEAL_D2,
    CHECK,
    DEAL_P3,
    CHECK_D,
    DEAL_D3,
    DONE
  } state_t;

  function automatic logic [RANK_W-1:0] card_value(
    input logic [RANK_W-1:0] rank
  );
    if (rank >= 4'd1 && rank <= 4'd9)
      return rank;
    return '0;
  endfunction

endpackage

// File: rtl/baccarat_fsm_dealer_draw_rule.sv
// Dealer third-card rule: dealer score vs player third-card value.
// Scores above 7 never draw.
module dealer_draw_rule
  import baccarat_pkg::*;
(
  input  logic [SCORE_W-1:0] dscore,
  input  logic [RANK_W-1:0]  v,
  output logic               draw
);

  always_comb begin
    draw = 1'b0;
    case (dscore)
      4'd0, 4'd1, 4'd2: draw = 1'b1;
      4'd3: draw = (v != 4'd8);
      4'd4: draw = (v >= 4'd2) && (v <= 4'd7);
      4'd5: draw = (v >= 4'd4) && (v <= 4'd7);
      4'd6: draw = (v >= 4'd6) && (v <= 4'd7);
      default: draw = 1'b0;
    endcase
  end

endmodule

// File: rtl/baccarat_fsm.sv
// Baccarat game sequencer: card load strobes,
// third-card decisions and win lights.
module baccarat_fsm
  import baccarat_pkg::*;
(
  input  logic               slow_clock,
  input  logic               resetb,
  input  logic [SCORE_W-1:0] pscore,
  input  logic [SCORE_W-1:0] dscore,
  input  logic [RANK_W-1:0]  pcard3,
  output logic               load_pcard1,
  output logic               load_pcard2,
  output logic               load_pcard3,
  output logic               load_dcard1,
  output logic               load_dcard2,
  output logic               load_dcard3,
  output logic               player_win_light,
  output logic               dealer_win_light
);

  state_t            state;
  state_t            state_n;
  logic              d_draw;
  logic [RANK_W-1:0] v;

  assign v = card_value(pcard3);

  dealer_draw_rule u_rule (
    .dscore (dscore),
    .v      (v),
    .draw   (d_draw)
  );

  always_ff @(posedge slow_clock) begin
    if (resetb) state <= DEAL_P1;
    else        state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      DEAL_P1: state_n = DEAL_D1;
      DEAL_D1: state_n = DEAL_P2;
      DEAL_P2: state_n = DEAL_D2;
      DEAL_D2: state_n = CHECK;
      CHECK: begin
        if (pscore >= NAT_MIN || dscore >= NAT_MIN)
          state_n = DONE;
        else if (pscore <= P_DRAW_MAX)
          state_n = DEAL_P3;
        else if (dscore <= P_DRAW_MAX)
          state_n = DEAL_D3;
        else
          state_n = DONE;
      end
      DEAL_P3: state_n = CHECK_D;
      CHECK_D: state_n = d_draw ? DEAL_D3 : DONE;
      DEAL_D3: state_n = DONE;
      DONE:    state_n = DONE;
      default: state_n = DEAL_P1;
    endcase
  end

  // Reset gates every output, including the DEAL_P1 strobe.
  always_comb begin
    load_pcard1      = 1'b0;
    load_pcard2      = 1'b0;
    load_pcard3      = 1'b0;
    load_dcard1      = 1'b0;
    load_dcard2      = 1'b0;
    load_dcard3      = 1'b0;
    player_win_light = 1'b0;
    dealer_win_light = 1'b0;
    if (!resetb) begin
      case (state)
        DEAL_P1: load_pcard1 = 1'b1;
        DEAL_D1: load_dcard1 = 1'b1;
        DEAL_P2: load_pcard2 = 1'b1;
        DEAL_D2: load_dcard2 = 1'b1;
        DEAL_P3: load_pcard3 = 1'b1;
        DEAL_D3: load_dcard3 = 1'b1;
        DONE: begin
          player_win_light = (pscore >= dscore);
          dealer_win_light = (dscore >= pscore);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/baccarat_fsm.md
# baccarat_fsm

Control FSM for the baccarat card game: the initiator side of the card datapath. It sequences the card-load strobes (player 1, dealer 1, player 2, dealer 2, then optional third cards), reads back the combinational hand scores and the player's third card, applies the third-card drawing rules, and drives the win lights. It advances exactly one state per `slow_clock` edge, the same edge on which the datapath's card registers sample `load_*`.

## Interface
Parameters: none. State encoding, rank width (4) and card-value rules are fixed in the shared package.

Ports:
- `slow_clock`  in  1  single clock; one game step per rising edge
- `resetb`  in  1  synchronous, active-high reset (asserted = 1; despite the name, polarity is high)
- `pscore`  in  4  player hand score 0..9 from the datapath scorer
- `dscore`  in  4  dealer hand score 0..9 from the datapath scorer
- `pcard3`  in  4  player third-card rank (0 = empty, 1..13 = A..K)
- `load_pcard1`, `load_pcard2`, `load_pcard3`  out  1 each  player card register load strobes
- `load_dcard1`, `load_dcard2`, `load_dcard3`  out  1 each  dealer card register load strobes
- `player_win_light`  out  1  player wins, or tie
- `dealer_win_light`  out  1  dealer wins, or tie

## Operation
- States: `DEAL_P1`, `DEAL_D1`, `DEAL_P2`, `DEAL_D2`, `CHECK`, `DEAL_P3`, `CHECK_D`, `DEAL_D3`, `DONE`.
- Moore outputs: exactly one `load_*` is high in each `DEAL_*` state (`DEAL_P1` drives `load_pcard1`, and so on). All loads are 0 in `CHECK`, `CHECK_D` and `DONE`.
- Fixed transitions: `DEAL_P1`→`DEAL_D1`→`DEAL_P2`→`DEAL_D2`→`CHECK`; `DEAL_P3`→`CHECK_D`; `DEAL_D3`→`DONE`; `DONE`→`DONE` until reset.
- `CHECK` (both scores valid):
  - `pscore` ≥ 8 or `dscore` ≥ 8 (natural) → `DONE`
  - else `pscore` ≤ 5 → `DEAL_P3`
  - else `dscore` ≤ 5 → `DEAL_D3`
  - else → `DONE`
- `CHECK_D`: compute v = value(`pcard3`), where rank 1..9 → rank and rank 0 or ≥10 → 0. Dealer draws (→ `DEAL_D3`, otherwise → `DONE`) when:
  - `dscore` 0..2: always
  - `dscore` 3: v ≠ 8
  - `dscore` 4: v ∈ 2..7
  - `dscore` 5: v ∈ 4..7
  - `dscore` 6: v ∈ 6..7
  - `dscore` 7: never
- Lights are high only in `DONE`:
  - `pscore` > `dscore`: player light only
  - `pscore` < `dscore`: dealer light only
  - equal: both lights
- Score inputs above 9 are out of contract; the only requirement is no lockup. All comparisons are unsigned 4-bit.

## Timing
- Reset: on a `slow_clock` edge with `resetb`=1, state goes to `DEAL_P1`. While `resetb`=1, every output is forced to 0, including `load_pcard1`. The datapath registers are cleared by the same reset.
- Reset mid-game, from any state, takes effect on the next edge with no partial completion. The game restarts at `DEAL_P1`.
- Edge numbering counts from the first edge with `resetb`=0. Edge 1 loads pcard1, edge 2 dcard1, edge 3 pcard2, edge 4 dcard2 and enters `CHECK`.
- The `CHECK` decision is taken on edge 5. Paths and their arrival in `DONE`:
  - natural: edge 5
  - player stands, dealer draws: `DEAL_D3` at edge 5, `DONE` at edge 6
  - player draws: `DEAL_P3` at edge 5, `CHECK_D` at edge 6 (`pcard3` valid), `DONE` or `DEAL_D3` at edge 7; a dealer third card reaches `DONE` at edge 8
- `pscore`, `dscore` and `pcard3` are sampled combinationally in the decision states. They must be settled one `slow_clock` period after the load edge.
- The lights are a combinational decode of state `DONE` and the scores, and stay stable while in `DONE`.

## Structure
- Shared package `baccarat_pkg` holds:
  - the `state_t` enum
  - rank/score width constants
  - the `card_value(rank)` function
  - the natural threshold (8) and the player draw threshold (5)
- One combinational sub-module, `dealer_draw_rule` (inputs `dscore`, v; output draw), is natural and unit-testable. The FSM instantiates it in `CHECK_D`.
- The state register is a single `always_ff` block with synchronous reset; outputs are decoded in `always_comb`.

## Test plan
- Natural: scores held at `pscore`=8, `dscore`=3 → `DONE` at edge 5; `load_pcard3` and `load_dcard3` never pulse; player light=1, dealer light=0.
- Player stands, dealer draws: `pscore`=6, `dscore`=5 at `CHECK` → `load_dcard3` high at edge 5, `DONE` at edge 6; then drive `dscore`=7 → dealer light only.
- Player draws, face card: `pscore`=3, `dscore`=4, `pcard3`=13 (v=0) → `CHECK_D` stands, `DONE` at edge 7; scores 4/4 → both lights.
- Dealer-rule boundaries at `CHECK_D`:
  - `dscore`=6: v=6 → draw, v=5 → stand
  - `dscore`=3: v=8 → stand, v=9 → draw
  - full game with a dealer draw ends in `DONE` at edge 8
- Reset mid-game: assert `resetb` during `DEAL_P3` → all outputs 0 during reset; after release, `load_pcard1`=1 and the 4-card sequence replays.
- Exhaustive `dealer_draw_rule`: all `dscore` 0..7 × v 0..9 checked against the rule list above.
